segment_spinner_decoder: RTL and testbench

//  Reads a 7-segment spinner display: samples the seven segment lines driven by the spinner/fader block,

---
 rtl/segment_spinner_pkg.sv | 40 ++++
 rtl/seg_duty_meter.sv | 72 +++++++
 rtl/segment_spinner_decoder.sv | 140 ++++++++++++++
 tb/tb_segment_spinner_decoder.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/segment_spinner_pkg.sv
// Shared types and constants for the segment spinner readback decoder.
//   state_t      : tracking FSM states
//   seg_idx_t    : segment index a..g (0..6)
//   phase_t      : 8-phase spin position
//   seg_phase()  : segment -> phase lookup (g is ambiguous, resolved by caller)
package segment_spinner_pkg;

  typedef enum logic [1:0] {IDLE, ACQUIRE, TRACK} state_t;

  typedef logic [2:0] seg_idx_t;
  typedef logic [2:0] phase_t;

  localparam int unsigned NUM_SEGS = 7;

  localparam seg_idx_t SEG_A = 3'd0;
  localparam seg_idx_t SEG_B = 3'd1;
  localparam seg_idx_t SEG_C = 3'd2;
  localparam seg_idx_t SEG_D = 3'd3;
  localparam seg_idx_t SEG_E = 3'd4;
  localparam seg_idx_t SEG_F = 3'd5;
  localparam seg_idx_t SEG_G = 3'd6;

  // g lights at both phase 2 and phase 6; only the previous phase tells them apart.
  localparam seg_idx_t G_SEGMENT = SEG_G;

  function automatic phase_t seg_phase(input seg_idx_t seg);
    phase_t p;
    case (seg)
      SEG_A:   p = 3'd0;
      SEG_B:   p = 3'd1;
      SEG_E:   p = 3'd3;
      SEG_D:   p = 3'd4;
      SEG_C:   p = 3'd5;
      SEG_F:   p = 3'd7;
      default: p = 3'd0;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/seg_duty_meter.sv
// Per-segment duty measurement over a free-running window.
//   clk, reset  : clock, async active-low reset
//   lit         : polarity-corrected segment lines (1 = lit)
//   head        : brightest segment of the last completed window (ties -> lowest index)
//   head_valid  : brightest count reached MIN_DUTY
//   done        : 1-cycle pulse when head/head_valid are updated
module seg_duty_meter
  import segment_spinner_pkg::*;
#(
  parameter int unsigned WINDOW_LOG2 = 8,
  parameter int unsigned MIN_DUTY    = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_SEGS-1:0] lit,
  output seg_idx_t            head,
  output logic                head_valid,
  output logic                done
);

  localparam int unsigned CNT_W = WINDOW_LOG2 + 1;
  localparam logic [WINDOW_LOG2-1:0] WIN_ONE = WINDOW_LOG2'(1);

  logic [WINDOW_LOG2-1:0] win_cnt;
  logic [CNT_W-1:0]       cnt      [NUM_SEGS];
  logic [CNT_W-1:0]       cnt_next [NUM_SEGS];
  logic                   win_first;
  logic                   win_last;
  seg_idx_t               best_idx;
  logic [CNT_W-1:0]       best_cnt;

  assign win_first = (win_cnt == '0);
  assign win_last  = (win_cnt == '1);

  // The first window cycle restarts the count, so the last cycle's sample is
  // still included when argmax runs on cnt_next.
  always_comb begin
    for (int unsigned i = 0; i < NUM_SEGS; i++) begin
      cnt_next[i] = (win_first ? '0 : cnt[i]) + CNT_W'(lit[i]);
    end
  end

  always_comb begin
    best_idx = SEG_A;
    best_cnt = cnt_next[0];
    for (int unsigned i = 1; i < NUM_SEGS; i++) begin
      if (cnt_next[i] > best_cnt) begin
        best_cnt = cnt_next[i];
        best_idx = seg_idx_t'(i);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      win_cnt    <= '0;
      head       <= SEG_A;
      head_valid <= 1'b0;
      done       <= 1'b0;
      for (int unsigned i = 0; i < NUM_SEGS; i++) cnt[i] <= '0;
    end else begin
      win_cnt <= win_cnt + WIN_ONE;
      done    <= win_last;
      for (int unsigned i = 0; i < NUM_SEGS; i++) cnt[i] <= cnt_next[i];
      if (win_last) begin
        head       <= best_idx;
        head_valid <= (best_cnt >= CNT_W'(MIN_DUTY));
      end
    end
  end

endmodule

// File: rtl/segment_spinner_decoder.sv
// Spinner display readback: recovers spin phase, direction and step period
// from the seven segment lines of a spinner instance.
//   clk, reset   : clock, async active-low reset
//   seg_in       : raw segment lines, bit0 = a ... bit6 = g
//   phase        : decoded spin phase 0..7
//   phase_valid  : phase holds a decoded position
//   locked       : tracking a consistent rotation
//   direction    : 1 = phase incrementing, 0 = decrementing
//   step_strobe  : 1-cycle pulse per accepted step
//   step_period  : clk cycles between the last two accepted steps
//   seq_error    : 1-cycle pulse on an illegal phase jump
module segment_spinner_decoder
  import segment_spinner_pkg::*;
#(
  parameter int unsigned COMMON_ANODE = 1,
  parameter int unsigned WINDOW_LOG2  = 8,
  parameter int unsigned MIN_DUTY     = 8,
  parameter int unsigned PERIOD_WIDTH = 24
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [6:0]              seg_in,
  output logic [2:0]              phase,
  output logic                    phase_valid,
  output logic                    locked,
  output logic                    direction,
  output logic                    step_strobe,
  output logic [PERIOD_WIDTH-1:0] step_period,
  output logic                    seq_error
);

  localparam logic [6:0] SEG_DARK = (COMMON_ANODE != 0) ? 7'h7f : 7'h00;
  localparam phase_t STEP_FWD  = 3'd1;
  localparam phase_t STEP_BACK = 3'd7;
  localparam logic [PERIOD_WIDTH-1:0] PER_ONE = PERIOD_WIDTH'(1);

  logic [6:0] sync1, sync2, lit;
  seg_idx_t   head;
  logic       head_valid, done;
  state_t     state;
  phase_t     new_phase, step;
  logic       resolved;
  logic [PERIOD_WIDTH-1:0] period_cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1 <= SEG_DARK;
      sync2 <= SEG_DARK;
    end else begin
      sync1 <= seg_in;
      sync2 <= sync1;
    end
  end

  assign lit = (COMMON_ANODE != 0) ? ~sync2 : sync2;

  seg_duty_meter #(
    .WINDOW_LOG2 (WINDOW_LOG2),
    .MIN_DUTY    (MIN_DUTY)
  ) u_meter (
    .clk        (clk),
    .reset      (reset),
    .lit        (lit),
    .head       (head),
    .head_valid (head_valid),
    .done       (done)
  );

  always_comb begin
    new_phase = seg_phase(head);
    resolved  = 1'b1;
    if (head == G_SEGMENT) begin
      resolved  = 1'b0;
      new_phase = 3'd0;
      if (phase_valid && (phase == 3'd1 || phase == 3'd3)) begin
        resolved  = 1'b1;
        new_phase = 3'd2;
      end else if (phase_valid && (phase == 3'd5 || phase == 3'd7)) begin
        resolved  = 1'b1;
        new_phase = 3'd6;
      end
    end
    step = new_phase - phase;
  end

  // period_cnt restarts at 1 on the step/acquire edge so that the value seen
  // at the next step equals the number of clk cycles between the two edges.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      phase       <= '0;
      phase_valid <= 1'b0;
      locked      <= 1'b0;
      direction   <= 1'b0;
      step_strobe <= 1'b0;
      step_period <= '0;
      seq_error   <= 1'b0;
      period_cnt  <= '0;
    end else begin
      step_strobe <= 1'b0;
      seq_error   <= 1'b0;
      if (period_cnt != '1) period_cnt <= period_cnt + PER_ONE;
      if (done) begin
        if (!head_valid) begin
          state       <= IDLE;
          phase_valid <= 1'b0;
          locked      <= 1'b0;
        end else if (resolved) begin
          case (state)
            IDLE: begin
              state       <= ACQUIRE;
              phase       <= new_phase;
              phase_valid <= 1'b1;
              period_cnt  <= PER_ONE;
            end
            ACQUIRE, TRACK: begin
              if (step == STEP_FWD || step == STEP_BACK) begin
                state       <= TRACK;
                locked      <= 1'b1;
                direction   <= (step == STEP_FWD);
                phase       <= new_phase;
                step_strobe <= 1'b1;
                step_period <= period_cnt;
                period_cnt  <= PER_ONE;
              end else if (step != 3'd0) begin
                state      <= ACQUIRE;
                locked     <= 1'b0;
                phase      <= new_phase;
                seq_error  <= 1'b1;
                period_cnt <= PER_ONE;
              end
            end
            default: state <= IDLE;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_segment_spinner_decoder.sv
module tb_segment_spinner_decoder;

  localparam int NW    = 23;
  localparam int TOTAL = 24 * 256;

  localparam logic [6:0] SA = 7'h01, SB = 7'h02, SC = 7'h04, SD = 7'h08;
  localparam logic [6:0] SE = 7'h10, SF = 7'h20, SG = 7'h40, SN = 7'h00;

  logic        clk = 1'b0;
  logic        reset;
  logic [6:0]  seg_in;
  logic [2:0]  phase;
  logic        phase_valid, locked, direction, step_strobe, seq_error;
  logic [23:0] step_period;

  always #5 clk = ~clk;

  segment_spinner_decoder #(
    .COMMON_ANODE (1),
    .WINDOW_LOG2  (8),
    .MIN_DUTY     (8),
    .PERIOD_WIDTH (24)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .seg_in      (seg_in),
    .phase       (phase),
    .phase_valid (phase_valid),
    .locked      (locked),
    .direction   (direction),
    .step_strobe (step_strobe),
    .step_period (step_period),
    .seq_error   (seq_error)
  );

  typedef struct {
    logic [6:0] mask;
    int         duty;
    logic       ev;
    logic       pv;
    logic [2:0] ph;
    logic       lk, dir, stb, err;
    int         per;
  } win_t;

  typedef struct {
    int         cyc;
    logic       pv;
    logic [2:0] ph;
    logic       lk, dir, stb, err;
    int         per;
  } exp_t;

  win_t tbl [NW];
  exp_t q[$];
  int   checks = 0;
  int   failures = 0;
  int   edge_n = 0;
  logic run = 1'b0;

  task automatic row(input int k, input logic [6:0] m, input int d, input logic ev,
                     input logic pv, input logic [2:0] ph, input logic lk, input logic dir,
                     input logic stb, input logic err, input int per);
    tbl[k] = '{m, d, ev, pv, ph, lk, dir, stb, err, per};
  endtask

  // Window k is built from seg_in values present before edges 256k-2 .. 256k+253
  // (two synchroniser stages), so drive index j maps to window (j+2)/256.
  function automatic logic [6:0] drive(input int j);
    int k;
    int off;
    logic [6:0] l;
    k   = (j + 2) / 256;
    off = (j + 2) % 256;
    l   = SN;
    if (k < NW && off < tbl[k].duty) l = tbl[k].mask;
    return ~l;
  endfunction

  task automatic push(input int k);
    exp_t e;
    if (k < NW && tbl[k].ev) begin
      e.cyc = 256 * k + 257;
      e.pv  = tbl[k].pv;  e.ph  = tbl[k].ph;  e.lk  = tbl[k].lk;
      e.dir = tbl[k].dir; e.stb = tbl[k].stb; e.err = tbl[k].err;
      e.per = tbl[k].per;
      q.push_back(e);
    end
  endtask

  always @(posedge clk) if (run) edge_n <= edge_n + 1;

  // Monitor: any strobe/error pulse or change of the held outputs is an event.
  logic [30:0] prev_o = '0;
  logic [30:0] cur_o;
  exp_t        e_m;
  always @(negedge clk) begin
    if (run) begin
      cur_o = {phase_valid, phase, locked, direction, step_period};
      if (step_strobe || seq_error || cur_o != prev_o) begin
        checks++;
        if (q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_event cyc=%0d got pv=%0d ph=%0d lk=%0d dir=%0d stb=%0d err=%0d per=%0d expected no event",
                   edge_n, phase_valid, phase, locked, direction, step_strobe, seq_error, step_period);
        end else begin
          e_m = q.pop_front();
          if (edge_n != e_m.cyc || phase_valid !== e_m.pv || phase !== e_m.ph ||
              locked !== e_m.lk || direction !== e_m.dir || step_strobe !== e_m.stb ||
              seq_error !== e_m.err || step_period !== 24'(e_m.per)) begin
            failures++;
            $display("FAIL window_event got cyc=%0d pv=%0d ph=%0d lk=%0d dir=%0d stb=%0d err=%0d per=%0d expected cyc=%0d pv=%0d ph=%0d lk=%0d dir=%0d stb=%0d err=%0d per=%0d",
                     edge_n, phase_valid, phase, locked, direction, step_strobe, seq_error, step_period,
                     e_m.cyc, e_m.pv, e_m.ph, e_m.lk, e_m.dir, e_m.stb, e_m.err, e_m.per);
          end
        end
      end
      prev_o = cur_o;
    end
  end

  initial begin
    reset  = 1'b0;
    seg_in = 7'h7f;
    //   k  mask     duty ev    pv    ph    lk    dir   stb   err   per
    row( 0, SA,      256, 1'b1, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0,   0); // acquire a
    row( 1, SA,      256, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0,   0); // hold
    row( 2, SB,      256, 1'b1, 1'b1, 3'd1, 1'b1, 1'b1, 1'b1, 1'b0, 512); // lock, fwd
    row( 3, SG,      256, 1'b1, 1'b1, 3'd2, 1'b1, 1'b1, 1'b1, 1'b0, 256); // g after 1 -> 2
    row( 4, SE,      256, 1'b1, 1'b1, 3'd3, 1'b1, 1'b1, 1'b1, 1'b0, 256);
    row( 5, SE,      256, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0,   0); // track hold
    row( 6, SG,      256, 1'b1, 1'b1, 3'd2, 1'b1, 1'b0, 1'b1, 1'b0, 512); // reverse, g -> 2
    row( 7, SB,      256, 1'b1, 1'b1, 3'd1, 1'b1, 1'b0, 1'b1, 1'b0, 256);
    row( 8, SA,      256, 1'b1, 1'b1, 3'd0, 1'b1, 1'b0, 1'b1, 1'b0, 256);
    row( 9, SF,      256, 1'b1, 1'b1, 3'd7, 1'b1, 1'b0, 1'b1, 1'b0, 256); // 0 -> 7 wrap
    row(10, SG,      256, 1'b1, 1'b1, 3'd6, 1'b1, 1'b0, 1'b1, 1'b0, 256); // g after 7 -> 6
    row(11, SF,      256, 1'b1, 1'b1, 3'd7, 1'b1, 1'b1, 1'b1, 1'b0, 256);
    row(12, SA,      256, 1'b1, 1'b1, 3'd0, 1'b1, 1'b1, 1'b1, 1'b0, 256); // 7 -> 0 wrap
    row(13, SB,      256, 1'b1, 1'b1, 3'd1, 1'b1, 1'b1, 1'b1, 1'b0, 256);
    row(14, SC,      256, 1'b1, 1'b1, 3'd5, 1'b0, 1'b1, 1'b0, 1'b1, 256); // jump 4 in track
    row(15, SA,        4, 1'b1, 1'b0, 3'd5, 1'b0, 1'b1, 1'b0, 1'b0, 256); // below MIN_DUTY
    row(16, SA,        4, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0,   0);
    row(17, SA | SB, 200, 1'b1, 1'b1, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0, 256); // tie -> a
    row(18, SD,      256, 1'b1, 1'b1, 3'd4, 1'b0, 1'b1, 1'b0, 1'b1, 256); // jump 4 in acquire
    row(19, SE,      256, 1'b1, 1'b1, 3'd3, 1'b1, 1'b0, 1'b1, 1'b0, 256);
    row(20, SN,        0, 1'b1, 1'b0, 3'd3, 1'b0, 1'b0, 1'b0, 1'b0, 256); // dark -> idle
    row(21, SG,      256, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0,   0); // g unresolved
    row(22, SN,        0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0,   0);

    repeat (10) begin
      @(negedge clk);
      seg_in = 7'($urandom);
    end
    checks++;
    if ({phase_valid, phase, locked, direction, step_strobe, seq_error, step_period} !== '0) begin
      failures++;
      $display("FAIL reset_outputs got pv=%0d ph=%0d lk=%0d dir=%0d stb=%0d err=%0d per=%0d expected all 0",
               phase_valid, phase, locked, direction, step_strobe, seq_error, step_period);
    end

    push(0);
    reset  = 1'b1;
    run    = 1'b1;
    seg_in = drive(0);
    for (int j = 1; j < TOTAL; j++) begin
      @(negedge clk);
      seg_in = drive(j);
      if ((j + 2) % 256 == 0) push((j + 2) / 256);
      if (j == 256) begin
        checks++;
        if (phase_valid !== 1'b0) begin
          failures++;
          $display("FAIL first_window_latency got pv=%0d expected 0 at cyc=%0d", phase_valid, edge_n);
        end
      end
    end
    repeat (4) @(negedge clk);
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL missing_events got pending=%0d expected 0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
